// File: rtl/ddc_cfg_sequencer.sv
// ddc_cfg_sequencer: stops a DDC chain, flushes it, writes its settings in a fixed order, then restarts it.
// Optional macro DDC_CFG_FAST_RETUNE_EN: phase-only retunes skip stop/flush and rewrite just the NCO word.
module ddc_cfg_sequencer #(
  parameter logic [7:0] BASE         = 8'd0,
  parameter int         FLUSH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [9:0]  cfg_decim,
  input  logic [31:0] cfg_phase_inc,
  input  logic [17:0] cfg_scale,
  input  logic        cfg_realmode,
  input  logic        cfg_swap_iq,
  input  logic        run_req,
  output logic        run_out,
  output logic        set_stb,
  output logic [7:0]  set_addr,
  output logic [31:0] set_data,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CHECK = 4'd1;
  localparam logic [3:0] S_STOP  = 4'd2;
  localparam logic [3:0] S_FLUSH = 4'd3;
  localparam logic [3:0] S_W3    = 4'd4;
  localparam logic [3:0] S_W0    = 4'd5;
  localparam logic [3:0] S_W1    = 4'd6;
  localparam logic [3:0] S_W2    = 4'd7;
  localparam logic [3:0] S_ARM   = 4'd8;

  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);

`ifdef DDC_CFG_FAST_RETUNE_EN
  localparam logic FAST_EN = 1'b1;
`else
  localparam logic FAST_EN = 1'b0;
`endif

  logic [3:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fast_q, fast_d;
  logic        run_q;

  logic [9:0]  req_decim_q;
  logic [31:0] req_phase_q;
  logic [17:0] req_scale_q;
  logic        req_real_q, req_swap_q;

  logic [9:0]  sh_decim_q;
  logic [17:0] sh_scale_q;
  logic        sh_real_q, sh_swap_q, sh_valid_q;

  logic        set_stb_q;
  logic [7:0]  set_addr_q;
  logic [31:0] set_data_q;
  logic        cfg_done_q;

  logic        hb1, hb2;
  logic [9:0]  cic;
  logic        req_bad, fast_hit, force_low;
  logic        wr_stb;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hb1 = 1'b0;
    hb2 = 1'b0;
    cic = req_decim_q;
    if (req_decim_q[1:0] == 2'b00 && req_decim_q >= 10'd4) begin
      hb1 = 1'b1;
      hb2 = 1'b1;
      cic = {2'b00, req_decim_q[9:2]};
    end else if (!req_decim_q[0]) begin
      hb2 = 1'b1;
      cic = {1'b0, req_decim_q[9:1]};
    end
  end

  assign req_bad  = (cic == 10'd0) || (cic > 10'd255);
  assign fast_hit = FAST_EN && sh_valid_q &&
                    (req_decim_q == sh_decim_q) && (req_scale_q == sh_scale_q) &&
                    (req_real_q == sh_real_q) && (req_swap_q == sh_swap_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fast_d  = fast_q;
    case (state_q)
      S_IDLE:  if (cfg_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (req_bad) begin
          state_d = S_IDLE;
        end else if (fast_hit) begin
          state_d = S_W0;
          fast_d  = 1'b1;
        end else begin
          state_d = S_STOP;
          fast_d  = 1'b0;
        end
      end
      S_STOP: begin
        cnt_d   = FLUSH_LOAD;
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == 8'd0) state_d = S_W3;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_W3:    state_d = S_W0;
      S_W0:    state_d = fast_q ? S_ARM : S_W1;
      S_W1:    state_d = S_W2;
      S_W2:    state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields are decoded from the next state so the strobe lines up with the write state.
  always_comb begin
    wr_stb  = 1'b1;
    wr_addr = BASE;
    wr_data = 32'd0;
    case (state_d)
      S_W3: begin
        wr_addr = BASE + 8'd3;
        wr_data = {30'd0, req_real_q, req_swap_q};
      end
      S_W0: wr_data = req_phase_q;
      S_W1: begin
        wr_addr = BASE + 8'd1;
        wr_data = {14'd0, req_scale_q};
      end
      S_W2: begin
        wr_addr = BASE + 8'd2;
        wr_data = {22'd0, hb1, hb2, cic[7:0]};
      end
      default: wr_stb = 1'b0;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      fast_q      <= 1'b0;
      run_q       <= 1'b0;
      req_decim_q <= 10'd0;
      req_phase_q <= 32'd0;
      req_scale_q <= 18'd0;
      req_real_q  <= 1'b0;
      req_swap_q  <= 1'b0;
      sh_decim_q  <= 10'd0;
      sh_scale_q  <= 18'd0;
      sh_real_q   <= 1'b0;
      sh_swap_q   <= 1'b0;
      sh_valid_q  <= 1'b0;
      set_stb_q   <= 1'b0;
      set_addr_q  <= 8'd0;
      set_data_q  <= 32'd0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fast_q  <= fast_d;
      if (cfg_valid && cfg_ready) begin
        req_decim_q <= cfg_decim;
        req_phase_q <= cfg_phase_inc;
        req_scale_q <= cfg_scale;
        req_real_q  <= cfg_realmode;
        req_swap_q  <= cfg_swap_iq;
      end
      // run_req is frozen while a sequence is in flight and re-sampled from ARM onward.
      if (state_q == S_IDLE || state_q == S_ARM) run_q <= run_req;
      if (state_q == S_ARM) begin
        sh_decim_q <= req_decim_q;
        sh_scale_q <= req_scale_q;
        sh_real_q  <= req_real_q;
        sh_swap_q  <= req_swap_q;
        sh_valid_q <= 1'b1;
      end
      set_stb_q <= wr_stb;
      if (wr_stb) begin
        set_addr_q <= wr_addr;
        set_data_q <= wr_data;
      end
      cfg_done_q <= (state_q == S_ARM);
    end
  end

  assign force_low = !fast_q &&
                     (state_q == S_STOP || state_q == S_FLUSH || state_q == S_W3 ||
                      state_q == S_W0   || state_q == S_W1    || state_q == S_W2);

  assign cfg_ready = (state_q == S_IDLE);
  assign cfg_err   = (state_q == S_CHECK) && req_bad;
  assign run_out   = run_q && !force_low;
  assign set_stb   = set_stb_q;
  assign set_addr  = set_addr_q;
  assign set_data  = set_data_q;
  assign cfg_done  = cfg_done_q;

endmodule
